// File: rtl/mem_region_pkg.sv
// Shared types, default region table and decode helper for the memory region router.
package mem_region_pkg;

  localparam int unsigned REGION_AW           = 32;
  localparam int unsigned NUM_DEFAULT_REGIONS = 4;
  localparam int unsigned HIT_CALC_W          = 64;

  typedef struct packed {
    logic [REGION_AW-1:0] base;
    logic [REGION_AW-1:0] len;
  } region_t;

  localparam region_t ITCM_REGION   = '{base: 32'h0000_0000, len: 32'h0000_2000};
  localparam region_t DTCM_REGION   = '{base: 32'h0001_0000, len: 32'h0000_8000};
  localparam region_t CSR_REGION    = '{base: 32'h0003_0000, len: 32'h0001_0000};
  localparam region_t EXTMEM_REGION = '{base: 32'h2000_0000, len: 32'h0040_0000};

  // Index 0 is the least significant slice, so the concatenation lists the last region first.
  localparam logic [NUM_DEFAULT_REGIONS-1:0][REGION_AW-1:0] DEFAULT_REGION_BASE =
    {EXTMEM_REGION.base, CSR_REGION.base, DTCM_REGION.base, ITCM_REGION.base};
  localparam logic [NUM_DEFAULT_REGIONS-1:0][REGION_AW-1:0] DEFAULT_REGION_LEN =
    {EXTMEM_REGION.len, CSR_REGION.len, DTCM_REGION.len, ITCM_REGION.len};

  // Range check for any address width up to HIT_CALC_W; one extra bit lets a region end at the top of memory.
  function automatic logic region_hit(input logic [HIT_CALC_W-1:0] addr,
                                      input logic [HIT_CALC_W-1:0] base,
                                      input logic [HIT_CALC_W-1:0] len);
    logic [HIT_CALC_W:0] lim;
    lim = {1'b0, base} + {1'b0, len};
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/rsp_id_fifo.sv
// Synchronous FIFO holding the target ID of each outstanding request, in issue order.
module rsp_id_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty_c = (wr_ptr == rd_ptr);
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;
  assign rdata_c = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; a push into a full FIFO is dropped even if a pop happens alongside.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/mem_region_router.sv
// Address decode and in-order request/response routing from one host port to NUM_REGIONS targets.
module mem_region_router
  import mem_region_pkg::*;
#(
  parameter int unsigned NUM_REGIONS     = NUM_DEFAULT_REGIONS,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE = DEFAULT_REGION_BASE,
  parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_LEN  = DEFAULT_REGION_LEN
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [ADDR_W-1:0]             req_addr_i,
  input  logic                          req_we_i,
  input  logic [DATA_W-1:0]             req_wdata_i,
  input  logic [DATA_W/8-1:0]           req_be_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [DATA_W-1:0]             rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic [NUM_REGIONS-1:0]        tgt_req_valid_o,
  input  logic [NUM_REGIONS-1:0]        tgt_req_ready_i,
  output logic [ADDR_W-1:0]             tgt_addr_o,
  output logic                          tgt_we_o,
  output logic [DATA_W-1:0]             tgt_wdata_o,
  output logic [DATA_W/8-1:0]           tgt_be_o,
  input  logic [NUM_REGIONS-1:0]        tgt_rsp_valid_i,
  output logic [NUM_REGIONS-1:0]        tgt_rsp_ready_o,
  input  logic [NUM_REGIONS*DATA_W-1:0] tgt_rsp_rdata_i,
  input  logic [NUM_REGIONS-1:0]        tgt_rsp_err_i,
  output logic [15:0]                   err_count_o,
  output logic [ADDR_W-1:0]             last_err_addr_o
);

  localparam int unsigned ID_W   = $clog2(NUM_REGIONS + 1);
  localparam logic [ID_W-1:0] ERR_ID = ID_W'(NUM_REGIONS);

  logic              hit;
  logic [ID_W-1:0]   hit_idx;
  logic [ADDR_W-1:0] hit_base;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ID_W-1:0]   head_id;
  logic [ID_W-1:0]   push_id;
  logic              push;
  logic              pop;
  logic              load;
  logic [DATA_W-1:0] nxt_rdata;
  logic              nxt_err;

  // Region decode; scanning from the top down leaves the lowest matching index in place.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_base = '0;
    for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
      if (region_hit(HIT_CALC_W'(req_addr_i), HIT_CALC_W'(REGION_BASE[i]), HIT_CALC_W'(REGION_LEN[i]))) begin
        hit      = 1'b1;
        hit_idx  = ID_W'(i);
        hit_base = REGION_BASE[i];
      end
    end
  end

  // Request steering; misses are accepted locally and tagged with the error ID.
  always_comb begin
    req_ready_o     = !fifo_full;
    tgt_req_valid_o = '0;
    push_id         = ERR_ID;
    if (hit) begin
      push_id = hit_idx;
      for (int i = 0; i < int'(NUM_REGIONS); i++) begin
        if (hit_idx == ID_W'(i)) begin
          tgt_req_valid_o[i] = req_valid_i && !fifo_full;
          req_ready_o        = tgt_req_ready_i[i] && !fifo_full;
        end
      end
    end
  end

  assign push        = req_valid_i && req_ready_o;
  assign tgt_addr_o  = req_addr_i - hit_base;
  assign tgt_we_o    = req_we_i;
  assign tgt_wdata_o = req_wdata_i;
  assign tgt_be_o    = req_be_i;

  // Response selection: only the target at the FIFO head may hand over data.
  always_comb begin
    load            = !rsp_valid_o || rsp_ready_i;
    tgt_rsp_ready_o = '0;
    pop             = 1'b0;
    nxt_rdata       = '0;
    nxt_err         = 1'b1;
    if (!fifo_empty) begin
      if (head_id == ERR_ID) begin
        pop = load;
      end else begin
        for (int i = 0; i < int'(NUM_REGIONS); i++) begin
          if (head_id == ID_W'(i)) begin
            tgt_rsp_ready_o[i] = load;
            pop                = load && tgt_rsp_valid_i[i];
            nxt_rdata          = tgt_rsp_rdata_i[i*DATA_W +: DATA_W];
            nxt_err            = tgt_rsp_err_i[i];
          end
        end
      end
    end
  end

  // Host response register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (load) begin
      rsp_valid_o <= pop;
      if (pop) begin
        rsp_rdata_o <= nxt_rdata;
        rsp_err_o   <= nxt_err;
      end
    end
  end

  // Decode error statistics.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_count_o     <= '0;
      last_err_addr_o <= '0;
    end else if (push && !hit) begin
      if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
      last_err_addr_o <= req_addr_i;
    end
  end

  rsp_id_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .push    (push),
    .wdata   (push_id),
    .pop     (pop),
    .rdata_c (head_id),
    .full_c  (fifo_full),
    .empty_c (fifo_empty)
  );

endmodule

// File: doc/mem_region_router.md
# mem_region_router

Parametrised address-decode and routing stage between a single host request port and `NUM_REGIONS` memory targets, such as ITCM, DTCM, CSR and external SRAM. It replaces the static per-region decode functions with a configurable region table and a valid/ready request path. It keeps responses in order through an outstanding-ID FIFO. Unmapped accesses complete locally with an error response, and the block captures error statistics.

## Interface
Parameters:
- `NUM_REGIONS`, 4, number of target regions/ports.
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; `DATA_W/8` byte enables.
- `MAX_OUTSTANDING`, 4, ID FIFO depth (power of 2, ≥2).
- `REGION_BASE`, {32'h0000_0000, 32'h0001_0000, 32'h0003_0000, 32'h2000_0000}, per-region base addresses.
- `REGION_LEN`, {32'h2000, 32'h8000, 32'h1_0000, 32'h40_0000}, per-region lengths in bytes; 0 disables the region.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is synchronous and active-low.
- `req_valid_i` in 1, `req_ready_o` out 1: host request handshake.
- `req_addr_i` in ADDR_W, `req_we_i` in 1, `req_wdata_i` in DATA_W, `req_be_i` in DATA_W/8: host request payload.
- `rsp_valid_o` out 1, `rsp_ready_i` in 1: host response handshake.
- `rsp_rdata_o` out DATA_W, `rsp_err_o` out 1: host response payload.
- `tgt_req_valid_o` out NUM_REGIONS, `tgt_req_ready_i` in NUM_REGIONS: one-hot target request handshake.
- `tgt_addr_o` out ADDR_W: region-relative offset, `req_addr_i - REGION_BASE[hit]`.
- `tgt_we_o`, `tgt_wdata_o`, `tgt_be_o` out: request payload, broadcast to all targets.
- `tgt_rsp_valid_i` in NUM_REGIONS, `tgt_rsp_ready_o` out NUM_REGIONS: target response handshake.
- `tgt_rsp_rdata_i` in NUM_REGIONS*DATA_W, `tgt_rsp_err_i` in NUM_REGIONS: target response payload.
- `err_count_o` out 16: saturating count of decode errors.
- `last_err_addr_o` out ADDR_W: address of the most recent decode error.

## Operation
- Decode is combinational. Region i hits iff `addr >= BASE[i]` and `addr < BASE[i]+LEN[i]`, evaluated in ADDR_W+1 bits so a region ending at 2^ADDR_W is valid. On overlap the lowest index wins. No hit is a decode error.
- Request path is zero-latency and fully combinational:
  - Hit: `tgt_req_valid_o[hit] = req_valid_i && !fifo_full`; `req_ready_o = tgt_req_ready_i[hit] && !fifo_full`.
  - Miss: `req_ready_o = !fifo_full`; no target valid is raised.
- On a request handshake the block pushes the ID into the FIFO: the hit index, or `NUM_REGIONS` for an error. A push is blocked when the FIFO is full, even if a pop occurs in the same cycle.
- Response path uses an output register (`rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o`). Let `load = !rsp_valid_o || rsp_ready_i`.
  - Head ID h < NUM_REGIONS: `tgt_rsp_ready_o[h] = load`, all other bits 0. On the `tgt_rsp_valid_i[h]` handshake the register loads the target data and error, and the FIFO pops.
  - Head ID = NUM_REGIONS: when `load` is high, the register loads rdata=0, err=1, and the FIFO pops.
  - FIFO empty: all `tgt_rsp_ready_o` are 0, and stray target responses are not accepted.
- Error stats update on a decode-error request handshake:
  - `err_count_o` increments and saturates at 16'hFFFF.
  - `last_err_addr_o` loads `req_addr_i`.
- Both request and response handshakes may occur in the same cycle, so the FIFO pushes and pops simultaneously. Occupancy is unchanged.

## Timing
- Reset values: `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `err_count_o`=0, `last_err_addr_o`=0, FIFO empty.
- Request to target: 0 cycles.
- Target response handshake to `rsp_valid_o`: 1 cycle.
- Decode error: `rsp_valid_o` rises the cycle after the error ID reaches the FIFO head with `load` high. Minimum is 1 cycle after the request handshake.
- Throughput: one response per cycle while `rsp_ready_i` is held high.
- Reset mid-operation: the FIFO and response register are cleared and in-flight responses are lost. Targets must be reset together with the router.

## Structure
- Package `mem_region_pkg`:
  - `region_t` struct {base, len}.
  - Default region table constants (ITCM, DTCM, CSR, EXTMEM).
  - `NUM_DEFAULT_REGIONS`.
  - A parametrised `region_hit` function.
- Sub-module `rsp_id_fifo`: synchronous FIFO of width `$clog2(NUM_REGIONS+1)` and depth `MAX_OUTSTANDING`, with full/empty flags.

## Test plan
- Read at 32'h0001_0010 → `tgt_req_valid_o`=4'b0010 and `tgt_addr_o`=32'h10. Target returns 32'hCAFE_F00D one cycle later → host sees rdata=32'hCAFE_F00D, err=0.
- Access to 32'h1000_0000 (unmapped) → no target valid; the response the next cycle has err=1 and rdata=0; `err_count_o`=1; `last_err_addr_o`=32'h1000_0000.
- Issue ITCM, EXTMEM, ITCM requests back to back. EXTMEM answers before ITCM → the EXTMEM response is held off (`tgt_rsp_ready_o[3]`=0) and host responses arrive in issue order.
- Issue 4 requests to a stalled target → the 5th request sees `req_ready_o`=0. After one response pop the 5th request is accepted.
- Hold `rsp_ready_i`=0 for 3 cycles with a response pending → `rsp_valid_o` and its data stay stable and the target is back-pressured.
- Assert `rsp_ni`... specifically, assert `rst_ni`=0 with 2 requests outstanding → the next cycle `rsp_valid_o`=0, the FIFO is empty and the counters are 0. Issue 65536 decode errors → `err_count_o` saturates at 16'hFFFF.
